// File: rtl/id_scoreboard_pkg.sv
// Shared pipeline definitions: register-file geometry and the reasons an ID-stage
// instruction can be held back from issue.
package pipeline_pkg;

    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        NONE,
        RAW,
        LOAD_USE,
        SB_FULL
    } stall_reason_e;

endpackage

// File: rtl/id_scoreboard_if.sv
// IF/ID/EX/WB handshake and status bundle seen by the ID-stage scoreboard.
// The master side drives the pipeline inputs; the slave side is the scoreboard.
interface id_scoreboard_if #(
    parameter int STAT_W = 16
);
    import pipeline_pkg::*;

    logic              fs_to_ds_valid;
    logic              ds_allowin;
    reg_idx_t          ds_rs1;
    reg_idx_t          ds_rs2;
    logic              ds_rs1_use;
    logic              ds_rs2_use;
    reg_idx_t          ds_rd;
    logic              ds_we;
    logic              ds_is_load;
    logic              es_allowin;
    logic              ds_to_es_valid;
    logic              br_flush;
    logic              wb_we;
    reg_idx_t          wb_rd;
    logic              ds_valid;
    logic              ds_stall;
    logic [STAT_W-1:0] stall_cycles;
    logic              sb_err;

    modport master (
        output fs_to_ds_valid, ds_rs1, ds_rs2, ds_rs1_use, ds_rs2_use,
               ds_rd, ds_we, ds_is_load, es_allowin, br_flush, wb_we, wb_rd,
        input  ds_allowin, ds_to_es_valid, ds_valid, ds_stall, stall_cycles, sb_err
    );

    modport slave (
        input  fs_to_ds_valid, ds_rs1, ds_rs2, ds_rs1_use, ds_rs2_use,
               ds_rd, ds_we, ds_is_load, es_allowin, br_flush, wb_we, wb_rd,
        output ds_allowin, ds_to_es_valid, ds_valid, ds_stall, stall_cycles, sb_err
    );

endinterface

// File: rtl/id_scoreboard_counter.sv
// One register's pending-write counter: counts issued-but-unretired writers,
// holds at full/zero, and flags a retire that finds nothing outstanding.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             zero,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign full      = (cnt == CNT_MAX);
    assign zero      = (cnt == '0);
    assign underflow = dec & ~inc & zero;

    // A simultaneous issue and retire cancel out, so only one-sided events move the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc & ~dec & ~full) begin
            cnt <= cnt + 1'b1;
        end else if (dec & ~inc & ~zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage issue control with a per-register pending-write scoreboard.
// Define SB_BYPASS_EN when EX forwards results: only load-use hazards stall operands.
module id_scoreboard #(
    parameter int NREG   = pipeline_pkg::NREG,
    parameter int CNT_W  = 2,
    parameter int STAT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    id_scoreboard_if.slave sb
);
    import pipeline_pkg::*;

    logic                       ds_valid_q;
    logic [STAT_W-1:0]          stall_cycles_q;
    logic                       sb_err_q;
    logic                       ds_ready_go;
    logic                       issue;
    logic                       rs1_live;
    logic                       rs2_live;
    logic                       src_hazard;
    logic                       sb_full;
    stall_reason_e              stall_reason;

    logic [NREG-1:0]            full_v;
    logic [NREG-1:0]            zero_v;
    logic [NREG-1:0]            underflow_v;
    logic [NREG-1:0][CNT_W-1:0] cnt_v;

    // x0 is never tracked, so its slot is tied to an always-empty counter.
    assign full_v[0]      = 1'b0;
    assign zero_v[0]      = 1'b1;
    assign underflow_v[0] = 1'b0;
    assign cnt_v[0]       = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        logic inc;
        logic dec;

        assign inc = issue & sb.ds_we & (sb.ds_rd == reg_idx_t'(i));
        assign dec = sb.wb_we & (sb.wb_rd == reg_idx_t'(i));

        sb_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      (inc),
            .dec      (dec),
            .cnt      (cnt_v[i]),
            .full     (full_v[i]),
            .zero     (zero_v[i]),
            .underflow(underflow_v[i])
        );
    end

    assign rs1_live = sb.ds_rs1_use & (sb.ds_rs1 != '0);
    assign rs2_live = sb.ds_rs2_use & (sb.ds_rs2 != '0);
    assign sb_full  = sb.ds_we & (sb.ds_rd != '0) & full_v[sb.ds_rd];

`ifdef SB_BYPASS_EN
    localparam stall_reason_e SRC_REASON = LOAD_USE;

    logic     load_in_ex;
    reg_idx_t load_rd;

    assign src_hazard = load_in_ex & ((rs1_live & (load_rd == sb.ds_rs1)) |
                                      (rs2_live & (load_rd == sb.ds_rs2)));
`else
    localparam stall_reason_e SRC_REASON = RAW;

    assign src_hazard = (rs1_live & ~zero_v[sb.ds_rs1]) |
                        (rs2_live & ~zero_v[sb.ds_rs2]);
`endif

    // Operand hazards take precedence when naming why the slot is held.
    always_comb begin
        stall_reason = NONE;
        if (src_hazard) begin
            stall_reason = SRC_REASON;
        end else if (sb_full) begin
            stall_reason = SB_FULL;
        end
    end

    assign ds_ready_go       = (stall_reason == NONE);
    assign issue             = ds_valid_q & ds_ready_go & sb.es_allowin;
    assign sb.ds_valid       = ds_valid_q;
    assign sb.ds_allowin     = ~ds_valid_q | (ds_ready_go & sb.es_allowin);
    assign sb.ds_to_es_valid = ds_valid_q & ds_ready_go;
    assign sb.ds_stall       = ds_valid_q & ~(ds_ready_go & sb.es_allowin);
    assign sb.stall_cycles   = stall_cycles_q;
    assign sb.sb_err         = sb_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_valid_q     <= 1'b0;
            stall_cycles_q <= '0;
            sb_err_q       <= 1'b0;
        end else begin
            if (sb.ds_allowin) begin
                ds_valid_q <= sb.fs_to_ds_valid & ~sb.br_flush;
            end
            if (sb.ds_stall && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
            sb_err_q <= sb_err_q | (|underflow_v);
        end
    end

`ifdef SB_BYPASS_EN
    // A load's result is unavailable for exactly the one cycle it spends in EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_in_ex <= 1'b0;
            load_rd    <= '0;
        end else if (issue & sb.ds_is_load & sb.ds_we & (sb.ds_rd != '0)) begin
            load_in_ex <= 1'b1;
            load_rd    <= sb.ds_rd;
        end else if (sb.es_allowin) begin
            load_in_ex <= 1'b0;
            load_rd    <= '0;
        end
    end

    logic unused_sb;
    assign unused_sb = ^{cnt_v, zero_v};
`else
    logic unused_sb;
    assign unused_sb = ^{cnt_v, sb.ds_is_load};
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed pipeline scenarios followed by
// randomized traffic, all compared against a pending-writer count model.
module tb_id_scoreboard;

    localparam int TB_STAT_W = 4;
    localparam int STAT_MAX  = (1 << TB_STAT_W) - 1;
    localparam int CNT_MAX   = 3;

    typedef struct {
        bit       fv;
        bit [4:0] rs1;
        bit       u1;
        bit [4:0] rs2;
        bit       u2;
        bit [4:0] rd;
        bit       we;
        bit       ld;
        bit       ea;
        bit       fl;
        bit       wwe;
        bit [4:0] wrd;
    } stim_t;

    logic clk;
    logic rst_n;

    id_scoreboard_if #(.STAT_W(TB_STAT_W)) sb ();

    id_scoreboard #(
        .NREG  (32),
        .CNT_W (2),
        .STAT_W(TB_STAT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb   (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    stim_t cur;
    int    pend [32];
    bit    m_valid;
    int    m_stall;
    bit    m_err;
    bit    m_lie;
    int    m_lrd;
    bit    m_captured;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.ea = 1'b1;
        return s;
    endfunction

    task automatic modelReset();
        foreach (pend[r]) pend[r] = 0;
        m_valid = 0;
        m_stall = 0;
        m_err   = 0;
        m_lie   = 0;
        m_lrd   = 0;
    endtask

    // An instruction may issue unless a source waits on an outstanding writer or its
    // destination already has the maximum number of writers in flight.
    function automatic bit modelReady(stim_t s);
        bit haz;
        haz = 0;
`ifdef SB_BYPASS_EN
        if (s.u1 && s.rs1 != 0 && m_lie && m_lrd == int'(s.rs1)) haz = 1;
        if (s.u2 && s.rs2 != 0 && m_lie && m_lrd == int'(s.rs2)) haz = 1;
`else
        if (s.u1 && s.rs1 != 0 && pend[s.rs1] > 0) haz = 1;
        if (s.u2 && s.rs2 != 0 && pend[s.rs2] > 0) haz = 1;
`endif
        if (s.we && s.rd != 0 && pend[s.rd] == CNT_MAX) haz = 1;
        return !haz;
    endfunction

    task automatic applyStimulus(input stim_t s);
        cur = s;
        sb.fs_to_ds_valid = s.fv;
        sb.ds_rs1         = s.rs1;
        sb.ds_rs1_use     = s.u1;
        sb.ds_rs2         = s.rs2;
        sb.ds_rs2_use     = s.u2;
        sb.ds_rd          = s.rd;
        sb.ds_we          = s.we;
        sb.ds_is_load     = s.ld;
        sb.es_allowin     = s.ea;
        sb.br_flush       = s.fl;
        sb.wb_we          = s.wwe;
        sb.wb_rd          = s.wrd;
        #1;
    endtask

    task automatic checkOutput();
        bit rdy;
        rdy = modelReady(cur);
        check("ds_valid",       sb.ds_valid,       m_valid);
        check("ds_allowin",     sb.ds_allowin,     !m_valid || (rdy && cur.ea));
        check("ds_to_es_valid", sb.ds_to_es_valid, m_valid && rdy);
        check("ds_stall",       sb.ds_stall,       m_valid && !(rdy && cur.ea));
        check("stall_cycles",   sb.stall_cycles,   m_stall);
        check("sb_err",         sb.sb_err,         m_err);
    endtask

    task automatic modelEdge();
        bit rdy, iss, alw, cancel;
        int ri;
        rdy = modelReady(cur);
        iss = m_valid && rdy && cur.ea;
        alw = !m_valid || (rdy && cur.ea);
        if (m_valid && !(rdy && cur.ea) && m_stall < STAT_MAX) m_stall++;
        ri = (iss && cur.we && cur.rd != 0) ? int'(cur.rd) : 0;
        cancel = 0;
        if (cur.wwe && cur.wrd != 0) begin
            if (int'(cur.wrd) == ri) cancel = 1;
            else if (pend[cur.wrd] == 0) m_err = 1;
            else pend[cur.wrd]--;
        end
        if (ri != 0 && !cancel) pend[ri]++;
        if (iss && cur.ld && cur.we && cur.rd != 0) begin
            m_lie = 1;
            m_lrd = int'(cur.rd);
        end else if (cur.ea) begin
            m_lie = 0;
            m_lrd = 0;
        end
        m_captured = alw && cur.fv && !cur.fl;
        if (alw) m_valid = cur.fv && !cur.fl;
    endtask

    task automatic step();
        checkOutput();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic cycle(input stim_t s);
        applyStimulus(s);
        step();
    endtask

    task automatic retire(input int r);
        stim_t s;
        s = idle();
        s.wwe = 1;
        s.wrd = 5'(r);
        cycle(s);
    endtask

    function automatic stim_t randInst();
        stim_t s;
        s = idle();
        s.rs1 = 5'($urandom_range(0, 7));
        s.u1  = 1'($urandom_range(0, 1));
        s.rs2 = 5'($urandom_range(0, 7));
        s.u2  = 1'($urandom_range(0, 1));
        s.rd  = 5'($urandom_range(0, 7));
        s.we  = ($urandom_range(0, 3) != 0);
        s.ld  = ($urandom_range(0, 3) == 0);
        return s;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        stim_t s, inst;
        int    sc0;
        int    cand[$];

        // Reset state.
        rst_n = 1'b0;
        modelReset();
        applyStimulus(idle());
        repeat (2) @(negedge clk);
        checkOutput();
        rst_n = 1'b1;

`ifndef SB_BYPASS_EN
        // Reader of x5 waits for x5's writer to retire, then issues.
        s = idle(); s.fv = 1; cycle(s);
        s = idle(); s.fv = 1; s.we = 1; s.rd = 5;
        applyStimulus(s); check("raw_writer_issue", sb.ds_to_es_valid, 1); step();
        s = idle(); s.u1 = 1; s.rs1 = 5; s.we = 1; s.rd = 6;
        applyStimulus(s); check("raw_stall", sb.ds_stall, 1); step();
        s.wwe = 1; s.wrd = 5;
        applyStimulus(s); check("raw_stall_at_retire", sb.ds_stall, 1); step();
        s.wwe = 0;
        applyStimulus(s); check("raw_issue_after_retire", sb.ds_to_es_valid, 1);
        check("raw_no_stall_after_retire", sb.ds_stall, 0); step();
        retire(6);
`else
        // Load-use costs exactly one bubble with forwarding.
        sc0 = m_stall;
        s = idle(); s.fv = 1; cycle(s);
        s = idle(); s.fv = 1; s.we = 1; s.rd = 7; s.ld = 1;
        applyStimulus(s); check("lu_load_issue", sb.ds_to_es_valid, 1); step();
        s = idle(); s.u1 = 1; s.rs1 = 7; s.we = 1; s.rd = 8;
        applyStimulus(s); check("lu_bubble", sb.ds_stall, 1); step();
        applyStimulus(s); check("lu_issue", sb.ds_to_es_valid, 1); step();
        applyStimulus(idle()); check("lu_stall_count", sb.stall_cycles, sc0 + 1); step();
        retire(7);
        retire(8);
`endif

        // Three writers to x9 fill its counter; the fourth waits for a retire.
        s = idle(); s.fv = 1; cycle(s);
        s.we = 1; s.rd = 9;
        repeat (3) cycle(s);
        s.fv = 0;
        applyStimulus(s); check("full_stall", sb.ds_stall, 1); step();
        s.wwe = 1; s.wrd = 9;
        applyStimulus(s); check("full_stall_at_retire", sb.ds_stall, 1); step();
        s.wwe = 0;
        applyStimulus(s); check("full_issue_after_retire", sb.ds_to_es_valid, 1); step();
        repeat (3) retire(9);

        // Same-edge issue/retire on x10 nets to zero; retiring idle x11 underflows.
        s = idle(); s.fv = 1; cycle(s);
        s.we = 1; s.rd = 10; cycle(s);
        s.fv = 0; s.wwe = 1; s.wrd = 10; cycle(s);
        retire(10);
        applyStimulus(idle()); check("same_edge_no_err", sb.sb_err, 0); step();
        retire(11);
        applyStimulus(idle()); check("underflow_err", sb.sb_err, 1); step();

        // Back-pressure from EX for four cycles, then a flush kills the arriving fetch.
        s = idle(); s.fv = 1; cycle(s);
        sc0 = m_stall;
        s = idle(); s.fv = 1; s.ea = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(s); check("backpressure_allowin", sb.ds_allowin, 0); step();
        end
        s = idle(); s.fv = 1; s.fl = 1;
        applyStimulus(s); check("backpressure_stall_count", sb.stall_cycles, sc0 + 4); step();
        applyStimulus(idle()); check("flush_kills_fetch", sb.ds_valid, 0); step();

        // Long stall saturates the narrow statistic counter.
        s = idle(); s.fv = 1; cycle(s);
        s = idle(); s.fv = 1; s.ea = 0;
        repeat (16) cycle(s);
        applyStimulus(s); check("stall_saturate", sb.stall_cycles, STAT_MAX);
        check("stall_held", sb.ds_stall, 1);

        // Asynchronous reset in the middle of the stall, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        check("async_rst_valid",   sb.ds_valid,       0);
        check("async_rst_allowin", sb.ds_allowin,     1);
        check("async_rst_to_es",   sb.ds_to_es_valid, 0);
        check("async_rst_stall",   sb.ds_stall,       0);
        check("async_rst_cycles",  sb.stall_cycles,   0);
        check("async_rst_err",     sb.sb_err,         0);
        @(negedge clk);
        rst_n = 1'b1;
        s = idle(); s.fv = 1; cycle(s);
        applyStimulus(idle()); check("capture_after_reset", sb.ds_valid, 1); step();

        // Randomized traffic; the ID fields stay put until a new instruction is captured.
        inst = randInst();
        for (int n = 0; n < 300; n++) begin
            s    = inst;
            s.fv = ($urandom_range(0, 3) != 0);
            s.ea = ($urandom_range(0, 4) != 0);
            s.fl = ($urandom_range(0, 15) == 0);
            cand.delete();
            for (int r = 1; r < 32; r++) if (pend[r] > 0) cand.push_back(r);
            if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
                s.wwe = 1;
                s.wrd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
            end else if ($urandom_range(0, 49) == 0) begin
                s.wwe = 1;
                s.wrd = 5'($urandom_range(0, 31));
            end
            cycle(s);
            if (m_captured) inst = randInst();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
